// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the CPU instruction and data memory ports onto one
// shared memory port. Only one transaction is outstanding at a time. Data
// requests win over instruction requests, but after STARVE_LIMIT consecutive
// data grants made while an instruction fetch is waiting, the fetch is forced
// through.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   imemory_*                instruction-side request (valid/instr/addr/wdata/
//                            wstrb in) and response (rdata/ready out)
//   dmemory_*                data-side request and response, same layout
//   memory_valid/instr/addr/wdata/wstrb   registered shared-port request
//   memory_rdata, memory_ready            shared-port response
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  imemory_valid,
    input  logic                  imemory_instr,
    input  logic [ADDR_WIDTH-1:0] imemory_addr,
    input  logic [31:0]           imemory_wdata,
    input  logic [3:0]            imemory_wstrb,
    output logic [31:0]           imemory_rdata,
    output logic                  imemory_ready,
    input  logic                  dmemory_valid,
    input  logic                  dmemory_instr,
    input  logic [ADDR_WIDTH-1:0] dmemory_addr,
    input  logic [31:0]           dmemory_wdata,
    input  logic [3:0]            dmemory_wstrb,
    output logic [31:0]           dmemory_rdata,
    output logic                  dmemory_ready,
    output logic                  memory_valid,
    output logic                  memory_instr,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    output logic [31:0]           memory_wdata,
    output logic [3:0]            memory_wstrb,
    input  logic [31:0]           memory_rdata,
    input  logic                  memory_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       grant_i;
    logic       grant_d;

    // Counter never exceeds LIMIT, so a fetch waiting long enough always
    // sees starve_cnt == LIMIT and gets forced through.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= LIMIT) ? LIMIT : v + 4'd1;
    endfunction

    // Arbitration only happens in IDLE; the completion cycle is spent in
    // BUSY_x, which gives the mandatory one-cycle gap between transactions.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (dmemory_valid && imemory_valid) begin
                if (starve_cnt == LIMIT) grant_i = 1'b1;
                else                     grant_d = 1'b1;
            end else if (dmemory_valid) begin
                grant_d = 1'b1;
            end else if (imemory_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= 4'd0;
            memory_valid <= 1'b0;
            memory_instr <= 1'b0;
            memory_addr  <= '0;
            memory_wdata <= 32'd0;
            memory_wstrb <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= BUSY_D;
                        memory_valid <= 1'b1;
                        memory_instr <= dmemory_instr;
                        memory_addr  <= dmemory_addr;
                        memory_wdata <= dmemory_wdata;
                        memory_wstrb <= dmemory_wstrb;
                        // Only count data grants that actually made a fetch wait.
                        starve_cnt   <= imemory_valid ? sat_inc(starve_cnt) : 4'd0;
                    end else if (grant_i) begin
                        state        <= BUSY_I;
                        memory_valid <= 1'b1;
                        memory_instr <= imemory_instr;
                        memory_addr  <= imemory_addr;
                        memory_wdata <= imemory_wdata;
                        memory_wstrb <= imemory_wstrb;
                        starve_cnt   <= 4'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Latched request stays put until the memory completes,
                    // even if the requester has already withdrawn.
                    if (memory_ready) begin
                        state        <= IDLE;
                        memory_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    memory_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion is routed combinationally to the owner only; a memory_ready
    // seen in IDLE reaches neither side.
    assign imemory_ready = (state == BUSY_I) && memory_ready;
    assign dmemory_ready = (state == BUSY_D) && memory_ready;
    assign imemory_rdata = imemory_ready ? memory_rdata : 32'd0;
    assign dmemory_rdata = dmemory_ready ? memory_rdata : 32'd0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Merges the CPU's instruction and data memory ports onto one shared memory port for single-ported memory/bus systems.
- Sits directly downstream of the cpu top and consumes its imemory_*/dmemory_* requests. Returns rdata/ready to the requesting side.
- One outstanding transaction at a time.
- Fixed data-over-instruction priority with a starvation guard for instruction fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits before instruction is forced (1..15)
ADDR_WIDTH, 32, address width of all ports

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-high
imemory_valid  in  1  instruction-side request; held until imemory_ready
imemory_instr  in  1  instruction-fetch flag
imemory_addr  in  ADDR_WIDTH  instruction-side address
imemory_wdata  in  32  instruction-side write data
imemory_wstrb  in  4  instruction-side byte strobes (0 = read)
imemory_rdata  out  32  read data to instruction side
imemory_ready  out  1  one-cycle completion pulse to instruction side
dmemory_valid  in  1  data-side request; held until dmemory_ready
dmemory_instr  in  1  data-side instr flag
dmemory_addr  in  ADDR_WIDTH  data-side address
dmemory_wdata  in  32  data-side write data
dmemory_wstrb  in  4  data-side byte strobes
dmemory_rdata  out  32  read data to data side
dmemory_ready  out  1  one-cycle completion pulse to data side
memory_valid  out  1  shared-port request, registered
memory_instr  out  1  shared-port instr flag, registered
memory_addr  out  ADDR_WIDTH  shared-port address, registered
memory_wdata  out  32  shared-port write data, registered
memory_wstrb  out  4  shared-port strobes, registered
memory_rdata  in  32  shared-port read data
memory_ready  in  1  shared-port completion pulse

Behaviour:
Reset:
- All memory_* outputs are 0. Both *_ready are 0 and both *_rdata are 0.
- State is IDLE. Starvation counter is 0.
- Reset asserted mid-transaction aborts it immediately: memory_valid drops asynchronously and no ready pulse is issued.

States:
- IDLE: no transaction.
- BUSY_I: instruction side owns the port.
- BUSY_D: data side owns the port.

Grant in IDLE, evaluated at the clock edge:
- Only dmemory_valid: grant D.
- Only imemory_valid: grant I.
- Both valid:
  - Grant I if starve_cnt == STARVE_LIMIT.
  - Otherwise grant D and increment starve_cnt.
- Neither: stay IDLE.

Starvation counter:
- Clears to 0 on any I grant.
- Clears to 0 on any D grant made while imemory_valid = 0.
- Saturates at STARVE_LIMIT.

On grant:
- Next cycle memory_valid = 1, with addr/wdata/wstrb/instr latched from the winner.
- The latched request is held stable until memory_ready.
- Latency: request seen at edge N, memory_valid high in cycle N+1.

Completion:
- In BUSY_x, when memory_ready = 1:
  - x_ready = 1 combinationally in the same cycle.
  - x_rdata = memory_rdata.
  - State goes to IDLE at the next edge, with memory_valid = 0 in the following cycle.
- Minimum spacing between back-to-back transactions is 2 cycles: no grant occurs in the completion cycle.
- The non-owning side's ready is always 0 and its rdata is always 0.
- memory_ready while in IDLE is ignored; no ready pulse is generated.

Request withdrawal:
- A requester dropping valid after grant does not abort the transaction.
- The transaction completes on the shared port and the ready pulse is still delivered to that side.

Writes and reads are treated identically; the arbiter does not inspect wstrb.

No combinational path from memory_ready to memory_valid.

Test Plan:
- Single read: imemory_valid=1, addr 0x100, wstrb 0; memory_ready pulse 3 cycles after memory_valid with rdata 0xDEADBEEF -> memory_valid 1 cycle after request with addr 0x100; imemory_ready pulses once with rdata 0xDEADBEEF; dmemory_ready stays 0.
- Simultaneous requests: I addr 0x200, D addr 0x8000 write with wdata 0x12345678 and wstrb 0xF -> D served first with memory_wstrb 0xF; I served next; memory_valid low for exactly 1 cycle between the two.
- Starvation, STARVE_LIMIT=4: dmemory_valid held high continuously with imemory_valid high -> exactly 4 D grants, then 1 I grant, then D resumes.
- Withdrawal: imemory_valid drops the cycle after grant -> memory_valid stays high until memory_ready, and imemory_ready still pulses.
- Mid-transaction reset: assert reset while BUSY_D -> memory_valid and all outputs go 0 without waiting for a clock edge; after release, IDLE with no spurious ready.
- Stray memory_ready=1 in IDLE -> no ready pulse on either side and no state change.
